// File: rtl/fp_cmp_scheduler.sv
`default_nettype none
// ============================================================================
// fp_cmp_scheduler : round-robin scheduler sharing one registered FP32
//   comparator among NREQ requesters. Optional NaN bypass: FP_CMP_NAN_EN.
// Revision: 1.0
// ============================================================================
module fp_cmp_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ*32-1:0]   req_a_i,
  input  logic [NREQ*32-1:0]   req_b_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [IDW-1:0]       rsp_id_o,
  output logic                 rsp_gr_o,
  output logic                 rsp_ls_o,
  output logic                 rsp_eq_o,
  output logic                 rsp_unord_o,
  output logic [31:0]          cmp_a_o,
  output logic [31:0]          cmp_b_o,
  input  logic                 cmp_gr_i,
  input  logic                 cmp_ls_i,
  input  logic                 cmp_eq_i,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t         state_q;
  logic [IDW-1:0] rr_q;
  logic [IDW-1:0] rsp_id_q;
  logic           rsp_valid_q;
  logic           rsp_gr_q;
  logic           rsp_ls_q;
  logic           rsp_eq_q;
  logic [31:0]    cmp_a_q;
  logic [31:0]    cmp_b_q;

  logic           any_valid;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] rr_next;
  logic [31:0]    grant_a;
  logic [31:0]    grant_b;
  logic           grant_nan;

  // Scan downward so the requester closest to rr_q is written last and wins.
  always_comb begin
    int base;
    int idx;
    any_valid = 1'b0;
    grant     = '0;
    base      = (int'(rr_q) >= NREQ) ? 0 : int'(rr_q);
    idx       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (base + k) % NREQ;
      if (req_valid_i[idx]) begin
        any_valid = 1'b1;
        grant     = IDW'(idx);
      end
    end
  end

  assign rr_next = IDW'((int'(grant) + 1) % NREQ);
  assign grant_a = req_a_i[32*grant +: 32];
  assign grant_b = req_b_i[32*grant +: 32];

  always_comb begin
    req_ready_o = '0;
    if (!rst && state_q == IDLE && any_valid) begin
      req_ready_o[grant] = 1'b1;
    end
  end

`ifdef FP_CMP_NAN_EN
  logic rsp_unord_q;

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  assign grant_nan   = is_nan(grant_a) || is_nan(grant_b);
  assign rsp_unord_o = rsp_unord_q;
`else
  assign grant_nan   = 1'b0;
  assign rsp_unord_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_gr_q    <= 1'b0;
      rsp_ls_q    <= 1'b0;
      rsp_eq_q    <= 1'b0;
      cmp_a_q     <= '0;
      cmp_b_q     <= '0;
`ifdef FP_CMP_NAN_EN
      rsp_unord_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_valid) begin
            rr_q     <= rr_next;
            rsp_id_q <= grant;
`ifdef FP_CMP_NAN_EN
            rsp_unord_q <= grant_nan;
`endif
            if (grant_nan) begin
              // Unordered result needs no comparator pass.
              rsp_valid_q <= 1'b1;
              rsp_gr_q    <= 1'b0;
              rsp_ls_q    <= 1'b0;
              rsp_eq_q    <= 1'b0;
              state_q     <= RESP;
            end else begin
              cmp_a_q <= grant_a;
              cmp_b_q <= grant_b;
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          rsp_gr_q    <= cmp_gr_i;
          rsp_ls_q    <= cmp_ls_i;
          rsp_eq_q    <= cmp_eq_i;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
      endcase
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_gr_o    = rsp_gr_q;
  assign rsp_ls_o    = rsp_ls_q;
  assign rsp_eq_o    = rsp_eq_q;
  assign cmp_a_o     = cmp_a_q;
  assign cmp_b_o     = cmp_b_q;
  assign busy_o      = (state_q != IDLE);

endmodule
`default_nettype wire
